// File: rtl/dvp_pkg.sv
// Shared types and default timing for the DVP transmitter.
// Used by dvp_tx and dvp_timing_gen; see dvp_tx.sv for the DVP_TX_TEST_PATTERN_EN option.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VS     = 3'd1,
    ST_VBLANK = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4
  } dvp_state_t;

  localparam int DVP_DATA_W   = 8;
  localparam int DVP_H_ACTIVE = 16;
  localparam int DVP_H_BLANK  = 4;
  localparam int DVP_V_ACTIVE = 8;
  localparam int DVP_VS_LINES = 1;
  localparam int DVP_V_BLANK  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of a counter that must hold 0..max_count (never narrower than 1 bit).
  function automatic int cnt_w(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// DVP frame/line state machine: slot phase toggle, pixel/line counters and strobes.
// Next-slot column/line ports exist only when DVP_TX_TEST_PATTERN_EN is defined.
module dvp_timing_gen
  import dvp_pkg::*;
#(
  parameter int  H_ACTIVE = DVP_H_ACTIVE,
  parameter int  H_BLANK  = DVP_H_BLANK,
  parameter int  V_ACTIVE = DVP_V_ACTIVE,
  parameter int  VS_LINES = DVP_VS_LINES,
  parameter int  V_BLANK  = DVP_V_BLANK,
  localparam int PIX_W    = cnt_w(H_ACTIVE + H_BLANK - 1),
  localparam int LINE_W   = cnt_w(max3(VS_LINES, V_BLANK, V_ACTIVE) - 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  output logic              phase_o,
  output logic              vsync_o,
  output logic              href_o,
  output logic              pix_req_o,
  output logic              idle_exit_o,
  output logic              frame_done_o
`ifdef DVP_TX_TEST_PATTERN_EN
  ,
  output logic              frame_start_o,
  output logic [PIX_W-1:0]  nxt_col_o,
  output logic [LINE_W-1:0] nxt_line_o
`endif
);

  localparam logic [PIX_W-1:0]  LINE_LAST = PIX_W'(H_ACTIVE + H_BLANK - 1);
  localparam logic [PIX_W-1:0]  ACT_LAST  = PIX_W'(H_ACTIVE - 1);
  localparam logic [PIX_W-1:0]  HBL_LAST  = PIX_W'(H_BLANK - 1);
  localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VS_LINES - 1);
  localparam logic [LINE_W-1:0] VBL_LAST  = LINE_W'(V_BLANK - 1);
  localparam logic [LINE_W-1:0] VACT_LAST = LINE_W'(V_ACTIVE - 1);

  dvp_state_t        state_q, state_d;
  logic              phase_q, phase_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      pix_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
    end
  end

  // Slot boundaries fall at the end of phase 1, i.e. on the pclk 1->0 edge.
  always_comb begin
    state_d = state_q;
    phase_d = ~phase_q;
    pix_d   = pix_q;
    line_d  = line_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = 1'b0;
        if (enable_i) state_d = ST_VS;
      end
      ST_VS: if (phase_q) begin
        if (pix_q == LINE_LAST) begin
          pix_d = '0;
          if (line_q == VS_LAST) begin
            line_d  = '0;
            state_d = ST_VBLANK;
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      ST_VBLANK: if (phase_q) begin
        if (pix_q == LINE_LAST) begin
          pix_d = '0;
          if (line_q == VBL_LAST) begin
            line_d  = '0;
            state_d = ST_ACTIVE;
          end else begin
            line_d = line_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      ST_ACTIVE: if (phase_q) begin
        if (pix_q == ACT_LAST) begin
          pix_d   = '0;
          state_d = ST_HBLANK;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      ST_HBLANK: if (phase_q) begin
        if (pix_q == HBL_LAST) begin
          pix_d = '0;
          if (line_q == VACT_LAST) begin
            line_d  = '0;
            done    = 1'b1;
            state_d = enable_i ? ST_VS : ST_IDLE;
          end else begin
            line_d  = line_q + 1'b1;
            state_d = ST_ACTIVE;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 1'b0;
        pix_d   = '0;
        line_d  = '0;
      end
    endcase
  end

  assign phase_o      = phase_q;
  assign vsync_o      = (state_q == ST_VS);
  assign href_o       = (state_q == ST_ACTIVE);
  assign pix_req_o    = phase_q && (state_d == ST_ACTIVE);
  assign idle_exit_o  = (state_q == ST_IDLE) && (state_d == ST_VS);
  assign frame_done_o = done;

`ifdef DVP_TX_TEST_PATTERN_EN
  assign frame_start_o = (state_d == ST_VS) && (state_q != ST_VS);
  assign nxt_col_o     = pix_d;
  assign nxt_line_o    = line_d;
`endif

endmodule

// File: rtl/dvp_tx.sv
// DVP transmitter top: pixel stream sink, output data register and sticky underrun flag.
// Define DVP_TX_TEST_PATTERN_EN to add pattern_i and the column^line test pattern generator.
module dvp_tx
  import dvp_pkg::*;
#(
  parameter int DATA_W   = DVP_DATA_W,
  parameter int H_ACTIVE = DVP_H_ACTIVE,
  parameter int H_BLANK  = DVP_H_BLANK,
  parameter int V_ACTIVE = DVP_V_ACTIVE,
  parameter int VS_LINES = DVP_VS_LINES,
  parameter int V_BLANK  = DVP_V_BLANK
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
`ifdef DVP_TX_TEST_PATTERN_EN
  input  logic              pattern_i,
`endif
  output logic              pclk_o,
  output logic              vsync_o,
  output logic              href_o,
  output logic [DATA_W-1:0] data_o,
  output logic              frame_done_o,
  output logic              underrun_o
);

  logic              slot_end;
  logic              pix_req;
  logic              idle_exit;
  logic [DATA_W-1:0] data_q, data_d;
  logic              underrun_q, underrun_d;

`ifdef DVP_TX_TEST_PATTERN_EN
  localparam int PIX_W  = cnt_w(H_ACTIVE + H_BLANK - 1);
  localparam int LINE_W = cnt_w(max3(VS_LINES, V_BLANK, V_ACTIVE) - 1);

  logic              frame_start;
  logic [PIX_W-1:0]  nxt_col;
  logic [LINE_W-1:0] nxt_line;
  logic              pattern_q;
  logic [DATA_W-1:0] pat_px;
`endif

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .VS_LINES (VS_LINES),
    .V_BLANK  (V_BLANK)
  ) u_timing (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .enable_i     (enable_i),
    .phase_o      (slot_end),
    .vsync_o      (vsync_o),
    .href_o       (href_o),
    .pix_req_o    (pix_req),
    .idle_exit_o  (idle_exit),
    .frame_done_o (frame_done_o)
`ifdef DVP_TX_TEST_PATTERN_EN
    ,
    .frame_start_o (frame_start),
    .nxt_col_o     (nxt_col),
    .nxt_line_o    (nxt_line)
`endif
  );

`ifdef DVP_TX_TEST_PATTERN_EN
  // Pattern mode is latched per frame so a mid-frame change of pattern_i has no effect.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pattern_q <= 1'b0;
    end else if (frame_start) begin
      pattern_q <= pattern_i;
    end
  end

  assign pat_px    = DATA_W'(nxt_col) ^ DATA_W'(nxt_line);
  assign s_ready_o = pix_req && !pattern_q;
`else
  assign s_ready_o = pix_req;
`endif

  // data_q loads only at slot boundaries, so data_o is stable across each pclk high phase.
  always_comb begin
    data_d     = data_q;
    underrun_d = underrun_q;
    if (idle_exit) underrun_d = 1'b0;
    if (slot_end) begin
      data_d = '0;
      if (s_ready_o) begin
        if (s_valid_i) data_d = s_data_i;
        else           underrun_d = 1'b1;
      end
`ifdef DVP_TX_TEST_PATTERN_EN
      if (pix_req && pattern_q) data_d = pat_px;
`endif
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      data_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      underrun_q <= underrun_d;
    end
  end

  assign pclk_o     = slot_end;
  assign data_o     = data_q;
  assign underrun_o = underrun_q;

endmodule

// File: doc/dvp_tx.md
DVP_TX -- requirements
Module: dvp_tx

Interface
REQ-001 Parameter DATA_W, default 8: pixel data width.
REQ-002 Parameter H_ACTIVE, default 16: active pixels per line.
REQ-003 Parameter H_BLANK, default 4: blank pixel slots per line, minimum 1.
REQ-004 Parameter V_ACTIVE, default 8: active lines per frame.
REQ-005 Parameter VS_LINES, default 1: line periods with vsync_o high.
REQ-006 Parameter V_BLANK, default 2: blank line periods after VSYNC, minimum 1.
REQ-007 wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-008 wb_rst_i  input  1  reset; synchronous, active-high.
REQ-009 enable_i  input  1  frame generation enable.
REQ-010 s_valid_i / s_data_i / s_ready_o  in/in/out  1/DATA_W/1  pixel stream sink.
REQ-011 pclk_o  output  1  DVP pixel clock, wb_clk_i/2.
REQ-012 vsync_o / href_o / data_o  output  1/1/DATA_W  DVP frame sync, line valid, pixel data.
REQ-013 frame_done_o  output  1  one-cycle pulse at frame end.
REQ-014 underrun_o  output  1  sticky flag: active pixel slot found no valid input.

Function
REQ-015 Each pixel slot SHALL be 2 cycles: phase 0 pclk_o=0, phase 1 pclk_o=1; pclk_o SHALL toggle every cycle except in IDLE, where it is held 0.
REQ-016 vsync_o, href_o and data_o SHALL change only on the edge where pclk_o goes 1->0, so the receiver sees stable data on the rising pclk_o edge.
REQ-017 States: IDLE, VS, VBLANK, ACTIVE, HBLANK. Each VS and VBLANK line period is H_ACTIVE+H_BLANK slots.
REQ-018 IDLE->VS when enable_i=1. VS lasts VS_LINES lines, then VBLANK. VBLANK lasts V_BLANK lines, then ACTIVE.
REQ-019 ACTIVE lasts H_ACTIVE slots with href_o=1, then HBLANK. HBLANK lasts H_BLANK slots with href_o=0 and data_o=0.
REQ-020 After the V_ACTIVE-th HBLANK, the block SHALL go to VS if enable_i=1, else to IDLE, and SHALL pulse frame_done_o for that cycle.
REQ-021 vsync_o SHALL be 1 only in VS. href_o SHALL be 1 only in ACTIVE.
REQ-022 enable_i SHALL be sampled only in IDLE and at frame end. Deassertion mid-frame SHALL let the current frame complete.
REQ-023 s_ready_o SHALL be 1 only in phase 1 of the slot that precedes an ACTIVE pixel slot. A pixel transfers when s_valid_i && s_ready_o; that pixel appears on data_o in the next slot.
REQ-024 If s_valid_i=0 while s_ready_o=1, the next slot SHALL output data_o=0 and set underrun_o. Timing SHALL NOT stall.
REQ-025 underrun_o SHALL clear only on reset or on the IDLE->VS transition.
REQ-026 Pixel and line counters SHALL be sized $clog2(max count + 1) and wrap to 0 at each state boundary.

Reset
REQ-027 On wb_rst_i=1, including mid-frame, the next cycle SHALL have: state IDLE, counters 0, pclk_o=0, vsync_o=0, href_o=0, data_o=0, s_ready_o=0, frame_done_o=0, underrun_o=0.
REQ-028 Reset SHALL take priority over enable_i and the stream handshake.

Configuration
REQ-029 Macro DVP_TX_TEST_PATTERN_EN, when defined, SHALL add input pattern_i (1 bit), sampled at frame start.
REQ-030 With pattern_i=1 for a frame: data_o = column[DATA_W-1:0] XOR line[DATA_W-1:0], s_ready_o held 0, underrun_o not set.
REQ-031 With the macro undefined, pattern_i and all generator logic SHALL be absent.

Structure
REQ-032 Package dvp_pkg SHALL hold the state enum type dvp_state_t and the default timing constants.
REQ-033 Sub-module dvp_timing_gen SHALL hold the state machine, the counters, the phase toggle and the ready/slot strobes. dvp_tx SHALL hold the data register, underrun logic and optional pattern logic.

Verification
REQ-034 Reset, enable_i=1, stream always valid with incrementing data from 0x00: check vsync_o high for 20 slots, then 40 blank slots, then 8 lines of 16 pixels 0x00..0x7F with href_o=1, and frame_done_o pulsing once.
REQ-035 Drop s_valid_i for pixel 5 of line 0: check data_o=0 in that slot, underrun_o=1 and sticky, frame timing unchanged.
REQ-036 Deassert enable_i on line 3: check the frame completes all 8 lines, then IDLE with pclk_o=0.
REQ-037 Assert wb_rst_i for 1 cycle mid-ACTIVE: check all outputs at reset values next cycle, and a fresh frame starts from VS after release.
REQ-038 Check all three protocol invariants across 3 back-to-back frames: data_o never changes while pclk_o=1; s_ready_o count equals 128 per frame; no gap between frames beyond VS+VBLANK.
REQ-039 With DVP_TX_TEST_PATTERN_EN defined and pattern_i=1: check line 2 pixel 5 data_o=0x07, and s_ready_o stays 0.
